// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM encodings and op-select values.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder; chained by the serial add/subtract unit to form its per-cycle ripple.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic z,
    output logic co
);

    assign z  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: BITS_PER_CYC operand bits per clock through a ripple of fa_cell,
// with a start/done handshake and registered result, carry-out and signed overflow.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned BITS_PER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / BITS_PER_CYC;
    localparam int unsigned CNT_W = $clog2(N + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               cmsb_q, cmsb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_d, done_d, co_d, ovf_d;
    logic [WIDTH-1:0]   z_d;

    logic [BITS_PER_CYC:0]   chain_c;
    logic [BITS_PER_CYC-1:0] sum_c;
    logic                    last_run_c;

    // Per-cycle ripple over the low slice of the operand shift registers
    assign chain_c[0] = carry_q;
    for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_fa
        fa_cell u_fa (
            .x  (op_a_q[i]),
            .y  (op_b_q[i]),
            .ci (chain_c[i]),
            .z  (sum_c[i]),
            .co (chain_c[i+1])
        );
    end

    assign last_run_c = (cnt_q == CNT_W'(N - 1));

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        z_d     = z;
        co_d    = co;
        ovf_d   = ovf;

        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                op_a_d  = op_a_q >> BITS_PER_CYC;
                op_b_d  = op_b_q >> BITS_PER_CYC;
                // Partial sums enter at the MSB end so the LSB slice lands at bit 0 after N shifts
                res_d   = WIDTH'({sum_c, res_q} >> BITS_PER_CYC);
                carry_d = chain_c[BITS_PER_CYC];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_run_c) begin
                    cmsb_d  = chain_c[BITS_PER_CYC-1];
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                end
            end
            ST_FIN: begin
                z_d     = res_q;
                co_d    = carry_q;
                ovf_d   = carry_q ^ cmsb_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept a request when idle or in the final cycle (back-to-back)
        if (start && (state_q == ST_IDLE || state_q == ST_FIN)) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            op_a_d  = a;
            op_b_d  = (sub == OP_SUB) ? ~b : b;
            carry_d = (sub == OP_SUB);
            cnt_d   = '0;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            z       <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            z       <= z_d;
            co      <= co_d;
            ovf     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: 8-bit directed/random ops and 4-bit exhaustive sweeps.
module tb_serial_addsub;

    typedef struct {
        logic [7:0] z;
        logic       co;
        logic       ovf;
        int         k;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, co8, ovf8;
    logic [7:0] z8;

    logic             start4 = 1'b0, sub4 = 1'b0;
    logic [3:0]       a4 = '0, b4 = '0;
    logic [2:0]       busy4, done4, co4, ovf4;
    logic [2:0][3:0]  z4;

    exp_t q8[$];
    exp_t q4[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(8), .BITS_PER_CYC(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .z(z8), .co(co8), .ovf(ovf8));

    serial_addsub #(.WIDTH(4), .BITS_PER_CYC(1)) u_w4b1 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4[0]), .done(done4[0]), .z(z4[0]), .co(co4[0]), .ovf(ovf4[0]));

    serial_addsub #(.WIDTH(4), .BITS_PER_CYC(2)) u_w4b2 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4[1]), .done(done4[1]), .z(z4[1]), .co(co4[1]), .ovf(ovf4[1]));

    serial_addsub #(.WIDTH(4), .BITS_PER_CYC(4)) u_w4b4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4[2]), .done(done4[2]), .z(z4[2]), .co(co4[2]), .ovf(ovf4[2]));

    // Reference: returns {ovf, co, z} packed; overflow derived from operand/result signs
    function automatic int unsigned model(input int unsigned w, input int unsigned av,
                                          input int unsigned bv, input bit s);
        int unsigned mask, bb, sum, zz, c, sa, sb, sz, v;
        mask = (32'd1 << w) - 32'd1;
        bb   = s ? (~bv & mask) : bv;
        sum  = av + bb + (s ? 32'd1 : 32'd0);
        zz   = sum & mask;
        c    = (sum >> w) & 32'd1;
        sa   = (av >> (w - 1)) & 32'd1;
        sb   = (bv >> (w - 1)) & 32'd1;
        sz   = (zz >> (w - 1)) & 32'd1;
        v    = s ? 32'((sa != sb) && (sz != sa)) : 32'((sa == sb) && (sz != sa));
        return zz | (c << w) | (v << (w + 1));
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_tests++;
        if ({busy8, done8, z8, co8, ovf8} !== 12'd0)
            $display("FAIL reset8: got %h required 0", {busy8, done8, z8, co8, ovf8});
        n_tests++;
        if ({busy4, done4, z4, co4, ovf4} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset4: got %h required 0", {busy4, done4, z4, co4, ovf4});
        end
        if ({busy8, done8, z8, co8, ovf8} !== 12'd0) n_fail++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                        input logic [7:0] ez, input logic eco, input logic eovf, input string name);
        exp_t e, g;
        logic [9:0] prev;
        bit got;
        @(negedge clk);
        prev = {z8, co8, ovf8};
        a8 = av; b8 = bv; sub8 = s; start8 = 1'b1;
        e.z = ez; e.co = eco; e.ovf = eovf; e.k = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0; a8 = ~av; b8 = 8'($urandom); sub8 = ~s;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done8) begin
                g = q8.pop_front();
                n_tests++;
                if ({z8, co8, ovf8} !== {g.z, g.co, g.ovf}) begin
                    n_fail++;
                    $display("FAIL %s result: got z=%h co=%b ovf=%b required z=%h co=%b ovf=%b",
                             name, z8, co8, ovf8, g.z, g.co, g.ovf);
                end
                n_tests++;
                if (cyc !== g.k + 9) begin
                    n_fail++;
                    $display("FAIL %s latency: got edge %0d required %0d", name, cyc, g.k + 9);
                end
                got = 1'b1;
            end else begin
                n_tests++;
                if ({z8, co8, ovf8} !== prev) begin
                    n_fail++;
                    $display("FAIL %s hold: got %h required %h", name, {z8, co8, ovf8}, prev);
                end
                @(negedge clk);
            end
        end
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: got no done required done", name);
            q8.delete();
        end else begin
            @(negedge clk);
            n_tests++;
            if (done8 !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done_pulse: got %b required 0", name, done8);
            end
        end
    endtask

    task automatic test_directed();
        run8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
        run8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    endtask

    task automatic test_random();
        int unsigned m;
        logic [7:0] av, bv;
        logic s;
        for (int i = 0; i < 6; i++) begin
            av = 8'($urandom); bv = 8'($urandom); s = 1'($urandom);
            m = model(8, 32'(av), 32'(bv), s);
            run8(av, bv, s, 8'(m), m[8], m[9], "random8");
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, g;
        logic [9:0] prev;
        int ndone, k2;
        bit pushed2;
        ndone = 0; pushed2 = 1'b0; k2 = 0;
        @(negedge clk);
        prev = {z8, co8, ovf8};
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
        e.z = 8'h33; e.co = 1'b0; e.ovf = 1'b0; e.k = cyc + 1;
        q8.push_back(e);
        for (int i = 0; i < 40 && ndone < 2; i++) begin
            @(negedge clk);
            if (done8) begin
                g = q8.pop_front();
                n_tests++;
                if ({z8, co8, ovf8, cyc} !== {g.z, g.co, g.ovf, g.k + 9}) begin
                    n_fail++;
                    $display("FAIL b2b op%0d: got z=%h co=%b ovf=%b edge=%0d required z=%h co=%b ovf=%b edge=%0d",
                             ndone, z8, co8, ovf8, cyc, g.z, g.co, g.ovf, g.k + 9);
                end
                ndone++;
                prev = {z8, co8, ovf8};
            end else begin
                n_tests++;
                if ({z8, co8, ovf8} !== prev) begin
                    n_fail++;
                    $display("FAIL b2b hold: got %h required %h", {z8, co8, ovf8}, prev);
                end
            end
            if (!pushed2) begin
                if (busy8) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
                end else begin
                    a8 = 8'h40; b8 = 8'h05; sub8 = 1'b1;
                    k2 = cyc + 1;
                    e.z = 8'h3B; e.co = 1'b1; e.ovf = 1'b0; e.k = k2;
                    q8.push_back(e);
                    pushed2 = 1'b1;
                end
            end else if (cyc >= k2) begin
                start8 = 1'b0;
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        if (ndone < 2) begin
            n_tests++; n_fail++;
            $display("FAIL b2b timeout: got %0d dones required 2", ndone);
            q8.delete();
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        @(negedge clk);
        a8 = 8'hC3; b8 = 8'h5A; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy8, done8, z8, co8, ovf8} !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h required 0", {busy8, done8, z8, co8, ovf8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_reset_done: got done pulse required none");
        end
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "post_reset");
    endtask

    task automatic test_exhaustive_w4();
        exp_t e, g;
        int unsigned m;
        int pending;
        for (int s = 0; s < 2; s++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    @(negedge clk);
                    a4 = 4'(av); b4 = 4'(bv); sub4 = 1'(s); start4 = 1'b1;
                    m = model(4, 32'(av), 32'(bv), 1'(s));
                    e.z = 8'(m & 32'hF); e.co = m[4]; e.ovf = m[5]; e.k = cyc + 1;
                    for (int j = 0; j < 3; j++) q4[j].push_back(e);
                    @(negedge clk);
                    start4 = 1'b0; a4 = ~a4; b4 = 4'($urandom); sub4 = ~sub4;
                    pending = 3;
                    for (int i = 0; i < 12 && pending > 0; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            if (done4[j]) begin
                                n_tests++;
                                if (q4[j].size() == 0) begin
                                    n_fail++;
                                    $display("FAIL w4_b%0d extra_done: got done required none", 1 << j);
                                end else begin
                                    g = q4[j].pop_front();
                                    pending--;
                                    if ({z4[j], co4[j], ovf4[j]} !== {g.z[3:0], g.co, g.ovf}) begin
                                        n_fail++;
                                        $display("FAIL w4_b%0d a=%0d b=%0d sub=%0d: got z=%h co=%b ovf=%b required z=%h co=%b ovf=%b",
                                                 1 << j, av, bv, s, z4[j], co4[j], ovf4[j], g.z[3:0], g.co, g.ovf);
                                    end
                                    n_tests++;
                                    if (cyc !== g.k + (4 >> j) + 1) begin
                                        n_fail++;
                                        $display("FAIL w4_b%0d latency: got edge %0d required %0d",
                                                 1 << j, cyc, g.k + (4 >> j) + 1);
                                    end
                                end
                            end
                        end
                        if (pending > 0) @(negedge clk);
                    end
                    if (pending > 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL w4 timeout: got %0d pending required 0", pending);
                        for (int j = 0; j < 3; j++) q4[j].delete();
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_w4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
